// File: rtl/eth_axis_downsizer.sv
// AXI-Stream width downsizer: one buffered wide beat is emitted as narrow slices,
// skipping all-zero-keep slices, preserving tlast and counting emitted frames.
module eth_axis_downsizer #(
  parameter int InDataWidth  = 64,
  parameter int OutDataWidth = 8,
  parameter int UserWidth    = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [InDataWidth-1:0]    s_tdata_i,
  input  logic [InDataWidth/8-1:0]  s_tkeep_i,
  input  logic                      s_tlast_i,
  input  logic [UserWidth-1:0]      s_tuser_i,
  input  logic                      s_tvalid_i,
  output logic                      s_tready_o,
  output logic [OutDataWidth-1:0]   m_tdata_o,
  output logic [OutDataWidth/8-1:0] m_tkeep_o,
  output logic                      m_tlast_o,
  output logic [UserWidth-1:0]      m_tuser_o,
  output logic                      m_tvalid_o,
  input  logic                      m_tready_i,
  output logic [31:0]               frame_cnt_o
);

  localparam int Ratio    = InDataWidth / OutDataWidth;
  localparam int InKeepW  = InDataWidth / 8;
  localparam int OutKeepW = OutDataWidth / 8;

  logic [InDataWidth-1:0]  buf_data_r;
  logic [InKeepW-1:0]      buf_keep_r;
  logic                    buf_last_r;
  logic [UserWidth-1:0]    buf_user_r;
  logic [Ratio-1:0]        rem_r;
  logic [OutDataWidth-1:0] m_data_r;
  logic [OutKeepW-1:0]     m_keep_r;
  logic                    m_last_r;
  logic [UserWidth-1:0]    m_user_r;
  logic                    m_valid_r;
  logic [31:0]             frame_cnt_r;

  logic                    s_ready_s;
  logic                    in_acc_s;
  logic                    out_hs_s;
  logic [Ratio-1:0]        in_mask_s;
  logic [Ratio-1:0]        src_mask_s;
  logic [Ratio-1:0]        sel_onehot_s;
  logic [Ratio-1:0]        rem_after_s;
  logic [InDataWidth-1:0]  src_data_s;
  logic [InKeepW-1:0]      src_keep_s;
  logic                    src_last_s;
  logic [UserWidth-1:0]    src_user_s;
  logic [OutDataWidth-1:0] sel_data_s;
  logic [OutKeepW-1:0]     sel_keep_s;

  // Ready when empty, or when the final pending slice leaves in this cycle.
  always_comb begin
    s_ready_s = ~m_valid_r | (m_tready_i & (rem_r == '0));
    in_acc_s  = s_tvalid_i & s_ready_s;
    out_hs_s  = m_valid_r & m_tready_i;
  end

  // Non-empty keep slices; an empty closing beat still yields slice 0 so tlast survives.
  always_comb begin
    in_mask_s = '0;
    for (int k = 0; k < Ratio; k++) begin
      in_mask_s[k] = |s_tkeep_i[k*OutKeepW +: OutKeepW];
    end
    in_mask_s[0] = in_mask_s[0] | (~(|s_tkeep_i) & s_tlast_i);
  end

  // Next slice comes from the incoming beat on a load, otherwise from the buffer.
  always_comb begin
    if (in_acc_s) begin
      src_data_s = s_tdata_i;
      src_keep_s = s_tkeep_i;
      src_last_s = s_tlast_i;
      src_user_s = s_tuser_i;
      src_mask_s = in_mask_s;
    end else begin
      src_data_s = buf_data_r;
      src_keep_s = buf_keep_r;
      src_last_s = buf_last_r;
      src_user_s = buf_user_r;
      src_mask_s = rem_r;
    end
    sel_onehot_s = src_mask_s & (~src_mask_s + Ratio'(1'b1));
    rem_after_s  = src_mask_s & ~sel_onehot_s;
    sel_data_s   = '0;
    sel_keep_s   = '0;
    for (int k = 0; k < Ratio; k++) begin
      sel_data_s = sel_data_s | ({OutDataWidth{sel_onehot_s[k]}} & src_data_s[k*OutDataWidth +: OutDataWidth]);
      sel_keep_s = sel_keep_s | ({OutKeepW{sel_onehot_s[k]}} & src_keep_s[k*OutKeepW +: OutKeepW]);
    end
  end

  // Input beat buffer, captured whole on every accept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_data_r <= '0;
      buf_keep_r <= '0;
      buf_last_r <= 1'b0;
      buf_user_r <= '0;
    end else if (in_acc_s) begin
      buf_data_r <= s_tdata_i;
      buf_keep_r <= s_tkeep_i;
      buf_last_r <= s_tlast_i;
      buf_user_r <= s_tuser_i;
    end
  end

  // Registered output slice and the mask of slices still to send after it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_valid_r <= 1'b0;
      m_data_r  <= '0;
      m_keep_r  <= '0;
      m_last_r  <= 1'b0;
      m_user_r  <= '0;
      rem_r     <= '0;
    end else if (in_acc_s | out_hs_s) begin
      if (src_mask_s != '0) begin
        m_valid_r <= 1'b1;
        m_data_r  <= sel_data_s;
        m_keep_r  <= sel_keep_s;
        m_last_r  <= src_last_s & (rem_after_s == '0);
        m_user_r  <= src_user_s;
        rem_r     <= rem_after_s;
      end else begin
        m_valid_r <= 1'b0;
        rem_r     <= '0;
      end
    end
  end

  // Emitted-frame counter, wraps naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frame_cnt_r <= 32'd0;
    end else if (out_hs_s & m_last_r) begin
      frame_cnt_r <= frame_cnt_r + 32'd1;
    end
  end

  assign s_tready_o  = s_ready_s;
  assign m_tdata_o   = m_data_r;
  assign m_tkeep_o   = m_keep_r;
  assign m_tlast_o   = m_last_r;
  assign m_tuser_o   = m_user_r;
  assign m_tvalid_o  = m_valid_r;
  assign frame_cnt_o = frame_cnt_r;

endmodule

// File: tb/tb_eth_axis_downsizer.sv
// Bench for eth_axis_downsizer: four width configurations driven with directed and
// random beats, checked every cycle against a slice-queue reference model.
module tb_eth_axis_downsizer;

  localparam int ND = 4;
  localparam int IWS [ND] = '{64, 64, 64, 128};
  localparam int OWS [ND] = '{8, 64, 32, 8};
  localparam logic [127:0] DPAT = 128'h100f0e0d0c0b0a09_0807060504030201;
  localparam logic [7:0] T0_D [21] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                                       8'h01, 8'h02, 8'h03, 8'h04,
                                       8'h01, 8'h03, 8'h06, 8'h08,
                                       8'h01,
                                       8'h05, 8'h06, 8'h07, 8'h08};

  typedef struct { logic [63:0] d; logic [7:0] k; logic l; logic u; logic eob; } beat_t;
  typedef struct { logic [127:0] d; logic [15:0] k; logic l; logic u; } in_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [127:0] s_data [ND];
  logic [15:0]  s_keep [ND];
  logic         s_last [ND];
  logic         s_user [ND];
  logic         s_valid[ND];
  logic         m_ready[ND];
  logic         s_ready[ND];
  logic         m_last [ND];
  logic         m_user [ND];
  logic         m_valid[ND];
  logic [31:0]  fcnt   [ND];
  logic [63:0]  m_data [ND];
  logic [7:0]   m_keep [ND];

  logic [7:0]  d0_data; logic       d0_keep;
  logic [63:0] d1_data; logic [7:0] d1_keep;
  logic [31:0] d2_data; logic [3:0] d2_keep;
  logic [7:0]  d3_data; logic       d3_keep;

  assign m_data[0] = {56'd0, d0_data}; assign m_keep[0] = {7'd0, d0_keep};
  assign m_data[1] = d1_data;          assign m_keep[1] = d1_keep;
  assign m_data[2] = {32'd0, d2_data}; assign m_keep[2] = {4'd0, d2_keep};
  assign m_data[3] = {56'd0, d3_data}; assign m_keep[3] = {7'd0, d3_keep};

  eth_axis_downsizer #(.InDataWidth(64), .OutDataWidth(8), .UserWidth(1)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n),
    .s_tdata_i(s_data[0][63:0]), .s_tkeep_i(s_keep[0][7:0]), .s_tlast_i(s_last[0]),
    .s_tuser_i(s_user[0]), .s_tvalid_i(s_valid[0]), .s_tready_o(s_ready[0]),
    .m_tdata_o(d0_data), .m_tkeep_o(d0_keep), .m_tlast_o(m_last[0]), .m_tuser_o(m_user[0]),
    .m_tvalid_o(m_valid[0]), .m_tready_i(m_ready[0]), .frame_cnt_o(fcnt[0]));

  eth_axis_downsizer #(.InDataWidth(64), .OutDataWidth(64), .UserWidth(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .s_tdata_i(s_data[1][63:0]), .s_tkeep_i(s_keep[1][7:0]), .s_tlast_i(s_last[1]),
    .s_tuser_i(s_user[1]), .s_tvalid_i(s_valid[1]), .s_tready_o(s_ready[1]),
    .m_tdata_o(d1_data), .m_tkeep_o(d1_keep), .m_tlast_o(m_last[1]), .m_tuser_o(m_user[1]),
    .m_tvalid_o(m_valid[1]), .m_tready_i(m_ready[1]), .frame_cnt_o(fcnt[1]));

  eth_axis_downsizer #(.InDataWidth(64), .OutDataWidth(32), .UserWidth(1)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n),
    .s_tdata_i(s_data[2][63:0]), .s_tkeep_i(s_keep[2][7:0]), .s_tlast_i(s_last[2]),
    .s_tuser_i(s_user[2]), .s_tvalid_i(s_valid[2]), .s_tready_o(s_ready[2]),
    .m_tdata_o(d2_data), .m_tkeep_o(d2_keep), .m_tlast_o(m_last[2]), .m_tuser_o(m_user[2]),
    .m_tvalid_o(m_valid[2]), .m_tready_i(m_ready[2]), .frame_cnt_o(fcnt[2]));

  eth_axis_downsizer #(.InDataWidth(128), .OutDataWidth(8), .UserWidth(1)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .s_tdata_i(s_data[3]), .s_tkeep_i(s_keep[3]), .s_tlast_i(s_last[3]),
    .s_tuser_i(s_user[3]), .s_tvalid_i(s_valid[3]), .s_tready_o(s_ready[3]),
    .m_tdata_o(d3_data), .m_tkeep_o(d3_keep), .m_tlast_o(m_last[3]), .m_tuser_o(m_user[3]),
    .m_tvalid_o(m_valid[3]), .m_tready_i(m_ready[3]), .frame_cnt_o(fcnt[3]));

  beat_t expq[ND][$];
  beat_t logq[ND][$];
  in_t   srcq[ND][$];
  int    exp_cnt[ND];
  int    nbeat[ND];
  bit    acc[ND];
  int    n_cmp, n_bad, phase;
  logic [20:0] t0_last;

  task automatic cmp(input string name, input int d, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0h expected %0h", name, d, act, exp);
    end
  endtask

  function automatic in_t make_in(logic [127:0] d, logic [15:0] k, logic l, logic u);
    in_t b;
    b.d = d; b.k = k; b.l = l; b.u = u;
    return b;
  endfunction

  function automatic in_t rand_in(logic l, bit full);
    in_t b;
    int r;
    r = $urandom_range(0, 7);
    b.d = {$urandom, $urandom, $urandom, $urandom};
    b.k = (full || r < 3) ? 16'hFFFF : (r == 3) ? 16'h0000 : 16'($urandom);
    b.l = l;
    b.u = 1'($urandom);
    return b;
  endfunction

  // Reference: an accepted beat becomes its non-empty slices in ascending order.
  task automatic push_beat(input int d, input in_t b);
    int ow, r, kw, n, c;
    logic [63:0] dm;
    logic [7:0] km;
    beat_t e;
    ow = OWS[d]; r = IWS[d] / ow; kw = ow / 8;
    dm = (ow == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << ow) - 64'd1);
    km = (kw == 8) ? 8'hFF : 8'((16'd1 << kw) - 16'd1);
    n = 0;
    for (int k = 0; k < r; k++) if ((8'(b.k >> (k * kw)) & km) != 8'd0) n++;
    if (n == 0) begin
      if (b.l) begin
        e.d = 64'(b.d) & dm; e.k = 8'd0; e.l = 1'b1; e.u = b.u; e.eob = 1'b1;
        expq[d].push_back(e);
      end
    end else begin
      c = 0;
      for (int k = 0; k < r; k++) begin
        e.k = 8'(b.k >> (k * kw)) & km;
        if (e.k != 8'd0) begin
          c++;
          e.d = 64'(b.d >> (k * ow)) & dm;
          e.u = b.u;
          e.eob = (c == n);
          e.l = b.l && (c == n);
          expq[d].push_back(e);
        end
      end
    end
  endtask

  task automatic apply(input int d, input in_t b);
    s_data[d] = b.d; s_keep[d] = b.k; s_last[d] = b.l; s_user[d] = b.u; s_valid[d] = 1'b1;
  endtask

  task automatic check_dut(input int d);
    logic ev, er;
    beat_t e, a;
    ev = (expq[d].size() != 0);
    er = !ev || (m_ready[d] && expq[d][0].eob);
    cmp("valid", d, m_valid[d], ev);
    cmp("s_ready", d, s_ready[d], er);
    cmp("frame_cnt", d, fcnt[d], exp_cnt[d]);
    if (m_valid[d] && ev) begin
      e = expq[d][0];
      cmp("beat", d, {m_data[d], m_keep[d], m_last[d], m_user[d]}, {e.d, e.k, e.l, e.u});
      if (m_ready[d]) begin
        void'(expq[d].pop_front());
        a.d = m_data[d]; a.k = m_keep[d]; a.l = m_last[d]; a.u = m_user[d]; a.eob = 1'b0;
        logq[d].push_back(a);
        if (e.l) exp_cnt[d]++;
      end
    end
    acc[d] = s_valid[d] && s_ready[d];
    if (acc[d]) push_beat(d, make_in(s_data[d], s_keep[d], s_last[d], s_user[d]));
  endtask

  task automatic drive(input int d);
    m_ready[d] = (phase == 2) ? ($urandom_range(0, 2) != 0) : 1'b1;
    if (!s_valid[d] || acc[d]) begin
      if (srcq[d].size() != 0) begin
        apply(d, srcq[d].pop_front());
      end else if (phase == 1) begin
        apply(d, rand_in(nbeat[d] % 3 == 2, 1'b1));
        nbeat[d]++;
      end else if (phase == 2 && $urandom_range(0, 3) != 0) begin
        apply(d, rand_in(nbeat[d] % 3 == 2, 1'b0));
        nbeat[d]++;
      end else begin
        s_valid[d] = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    for (int d = 0; d < ND; d++) check_dut(d);
    @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) drive(d);
  endtask

  task automatic drain(input int budget);
    int n;
    bit busy;
    phase = 0;
    n = 0;
    busy = 1'b1;
    while (busy && n < budget) begin
      cycle();
      n++;
      busy = 1'b0;
      for (int d = 0; d < ND; d++)
        if (expq[d].size() != 0 || srcq[d].size() != 0 || s_valid[d]) busy = 1'b1;
    end
    cmp("drain_timeout", -1, {127'd0, busy}, 128'd0);
  endtask

  initial begin
    beat_t b;
    t0_last = 21'h118880;
    n_cmp = 0; n_bad = 0; phase = 0;
    rst_n = 1'b0;
    for (int d = 0; d < ND; d++) begin
      s_valid[d] = 1'b0; m_ready[d] = 1'b1; exp_cnt[d] = 0; nbeat[d] = 0; acc[d] = 1'b0;
      srcq[d].push_back(make_in(DPAT, 16'hFFFF, 1'b1, 1'b1));
      srcq[d].push_back(make_in(DPAT, 16'h000F, 1'b1, 1'b0));
      srcq[d].push_back(make_in(DPAT, 16'h00A5, 1'b1, 1'b1));
      srcq[d].push_back(make_in(DPAT, 16'h0000, 1'b0, 1'b0));
      srcq[d].push_back(make_in(DPAT, 16'h0000, 1'b1, 1'b1));
      srcq[d].push_back(make_in(DPAT, 16'h00F0, 1'b1, 1'b0));
      apply(d, srcq[d].pop_front());
    end
    repeat (3) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        cmp("rst_valid", d, m_valid[d], 1'b0);
        cmp("rst_ready", d, s_ready[d], 1'b1);
        cmp("rst_cnt", d, fcnt[d], 32'd0);
      end
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    drain(300);

    // Hand-computed expectations for the directed beats.
    cmp("lit0_size", 0, logq[0].size(), 21);
    for (int i = 0; i < 21; i++) begin
      b = logq[0][i];
      cmp($sformatf("lit0_%0d", i), 0, {b.d[7:0], b.k[0], b.l}, {T0_D[i], (i != 16), t0_last[i]});
    end
    cmp("lit0_cnt", 0, fcnt[0], 32'd5);
    cmp("lit1_size", 1, logq[1].size(), 5);
    b = logq[1][0];
    cmp("lit1_full", 1, {b.d, b.k, b.l}, {64'h0807060504030201, 8'hFF, 1'b1});
    b = logq[1][3];
    cmp("lit1_zero", 1, {b.k, b.l}, {8'h00, 1'b1});
    cmp("lit2_size", 2, logq[2].size(), 7);
    b = logq[2][6];
    cmp("lit2_upper", 2, {b.d, b.k, b.l}, {64'h08070605, 8'h0F, 1'b1});
    cmp("lit3_size", 3, logq[3].size(), 29);
    b = logq[3][14];
    cmp("lit3_b14", 3, {b.d[7:0], b.l}, {8'h0F, 1'b0});
    b = logq[3][15];
    cmp("lit3_b15", 3, {b.d[7:0], b.l}, {8'h10, 1'b1});

    phase = 1;
    repeat (300) cycle();
    drain(400);
    phase = 2;
    repeat (3000) cycle();
    drain(600);

    // Reset in the middle of a frame.
    phase = 1;
    repeat (7) cycle();
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      cmp("mid_rst_out", d, {m_valid[d], m_data[d], m_keep[d], m_last[d], m_user[d]}, 128'd0);
      cmp("mid_rst_ready", d, s_ready[d], 1'b1);
      cmp("mid_rst_cnt", d, fcnt[d], 32'd0);
      expq[d].delete(); srcq[d].delete();
      exp_cnt[d] = 0; nbeat[d] = 0; acc[d] = 1'b0; s_valid[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    phase = 0;
    for (int d = 0; d < ND; d++) apply(d, make_in(DPAT, 16'hFFFF, 1'b1, 1'b0));
    drain(200);
    for (int d = 0; d < ND; d++) cmp("post_rst_cnt", d, fcnt[d], 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
